// File: rtl/ps2_controles_jogadores_pkg.sv
// Shared constants for the PS/2 arcade-control receiver: FSM states, scan codes and key map.
package ps2_pkg;

  localparam int unsigned MAX_JOGADORES = 4;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] DADOS    = 2'd1;
  localparam logic [1:0] PARIDADE = 2'd2;
  localparam logic [1:0] PARADA   = 2'd3;

  localparam logic [7:0] COD_LIBERAR   = 8'hF0;
  localparam logic [7:0] COD_ESTENDIDO = 8'hE0;
  localparam logic [7:0] COD_PAUSA     = 8'hE1;
  localparam logic [7:0] COD_OVF_ZERO  = 8'h00;
  localparam logic [7:0] COD_OVF_UM    = 8'hFF;

  typedef struct packed {
    logic       estendido;
    logic [7:0] codigo;
  } tecla_t;

  localparam tecla_t TECLA_A     = 9'h01C;
  localparam tecla_t TECLA_Z     = 9'h01A;
  localparam tecla_t TECLA_ESC   = 9'h076;
  localparam tecla_t TECLA_K     = 9'h042;
  localparam tecla_t TECLA_M     = 9'h03A;
  localparam tecla_t TECLA_F1    = 9'h005;
  localparam tecla_t TECLA_T     = 9'h02C;
  localparam tecla_t TECLA_G     = 9'h034;
  localparam tecla_t TECLA_F2    = 9'h006;
  localparam tecla_t TECLA_CIMA  = 9'h175;
  localparam tecla_t TECLA_BAIXO = 9'h172;
  localparam tecla_t TECLA_F3    = 9'h004;

  // Indexed by player: element 0 is player 0.
  localparam tecla_t [MAX_JOGADORES-1:0] TECLAS_SOBE   = {TECLA_CIMA, TECLA_T, TECLA_K, TECLA_A};
  localparam tecla_t [MAX_JOGADORES-1:0] TECLAS_DESCE  = {TECLA_BAIXO, TECLA_G, TECLA_M, TECLA_Z};
  localparam tecla_t [MAX_JOGADORES-1:0] TECLAS_INICIA = {TECLA_F3, TECLA_F2, TECLA_F1, TECLA_ESC};

  function automatic logic tecla_casa(input tecla_t t, input logic est, input logic [7:0] c);
    return (t.estendido == est) && (t.codigo == c);
  endfunction

endpackage

// File: rtl/ps2_controles_jogadores_if.sv
// PS/2 pins plus decoded control outputs; master is the receiver, slave the game core.
interface ps2_controles_jogadores_if #(
  parameter int unsigned NUM_JOGADORES = 2
);
  logic                     ps2relogio;
  logic                     ps2dados;
  logic [NUM_JOGADORES-1:0] sobe;
  logic [NUM_JOGADORES-1:0] desce;
  logic [NUM_JOGADORES-1:0] inicia;
  logic [7:0]               codigo;
  logic                     codigo_valido;
  logic                     erro_paridade;
  logic                     erro_quadro;

  modport master (
    input  ps2relogio, ps2dados,
    output sobe, desce, inicia, codigo, codigo_valido, erro_paridade, erro_quadro
  );

  modport slave (
    output ps2relogio, ps2dados,
    input  sobe, desce, inicia, codigo, codigo_valido, erro_paridade, erro_quadro
  );
endinterface

// File: rtl/ps2_controles_jogadores_receptor.sv
// PS/2 frame receiver: pin synchroniser, start/data/parity/stop FSM and inter-edge timeout.
module ps2_receptor
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS  = 16380,
  parameter int unsigned LARGURA_TIMEOUT = 15
) (
  input  logic       relogio50,
  input  logic       inicializa,
  input  logic       ps2relogio,
  input  logic       ps2dados,
  output logic [7:0] codigo,
  output logic       codigo_valido,
  output logic       erro_paridade,
  output logic       erro_quadro
);
  localparam logic [LARGURA_TIMEOUT-1:0] TIMEOUT_LIM = LARGURA_TIMEOUT'(TIMEOUT_CICLOS);
  localparam logic [LARGURA_TIMEOUT-1:0] CONT_MAX    = '1;

  logic [1:0] clk_sinc_q, dat_sinc_q;
  logic       clk_ant_q;
  logic       amostra, dado;

  logic [1:0]                 estado_q, estado_d;
  logic [2:0]                 cont_bits_q, cont_bits_d;
  logic [7:0]                 dados_q, dados_d;
  logic                       paridade_q, paridade_d;
  logic [7:0]                 codigo_q, codigo_d;
  logic                       valido_q, valido_d;
  logic                       erro_par_q, erro_par_d;
  logic                       erro_quad_q, erro_quad_d;
  logic [LARGURA_TIMEOUT-1:0] cont_q, cont_d;

  assign dado    = dat_sinc_q[1];
  assign amostra = clk_ant_q & ~clk_sinc_q[1];

  // Synchronisers reset to the idle-high line level so reset release never fakes an edge.
  always_ff @(posedge relogio50 or posedge inicializa) begin
    if (inicializa) begin
      clk_sinc_q <= 2'b11;
      dat_sinc_q <= 2'b11;
      clk_ant_q  <= 1'b1;
    end else begin
      clk_sinc_q <= {clk_sinc_q[0], ps2relogio};
      dat_sinc_q <= {dat_sinc_q[0], ps2dados};
      clk_ant_q  <= clk_sinc_q[1];
    end
  end

  always_comb begin
    estado_d    = estado_q;
    cont_bits_d = cont_bits_q;
    dados_d     = dados_q;
    paridade_d  = paridade_q;
    codigo_d    = codigo_q;
    valido_d    = 1'b0;
    erro_par_d  = 1'b0;
    erro_quad_d = 1'b0;

    if (amostra) begin
      cont_d = '0;
    end else if (cont_q != CONT_MAX) begin
      cont_d = cont_q + 1'b1;
    end else begin
      cont_d = cont_q;
    end

    // An edge in the same cycle as the timeout wins.
    if (amostra) begin
      case (estado_q)
        OCIOSO: begin
          if (!dado) begin
            estado_d    = DADOS;
            cont_bits_d = 3'd0;
          end
        end
        DADOS: begin
          dados_d     = {dado, dados_q[7:1]};
          cont_bits_d = cont_bits_q + 3'd1;
          if (cont_bits_q == 3'd7) estado_d = PARIDADE;
        end
        PARIDADE: begin
          paridade_d = dado;
          estado_d   = PARADA;
        end
        default: begin
          if (dado && (^{dados_q, paridade_q})) begin
            codigo_d = dados_q;
            valido_d = 1'b1;
          end else begin
            erro_par_d = 1'b1;
          end
          estado_d = OCIOSO;
        end
      endcase
    end else if ((cont_q == TIMEOUT_LIM) && (estado_q != OCIOSO)) begin
      erro_quad_d = 1'b1;
      estado_d    = OCIOSO;
    end
  end

  always_ff @(posedge relogio50 or posedge inicializa) begin
    if (inicializa) begin
      estado_q    <= OCIOSO;
      cont_bits_q <= 3'd0;
      dados_q     <= 8'h00;
      paridade_q  <= 1'b0;
      codigo_q    <= 8'h00;
      valido_q    <= 1'b0;
      erro_par_q  <= 1'b0;
      erro_quad_q <= 1'b0;
      cont_q      <= '0;
    end else begin
      estado_q    <= estado_d;
      cont_bits_q <= cont_bits_d;
      dados_q     <= dados_d;
      paridade_q  <= paridade_d;
      codigo_q    <= codigo_d;
      valido_q    <= valido_d;
      erro_par_q  <= erro_par_d;
      erro_quad_q <= erro_quad_d;
      cont_q      <= cont_d;
    end
  end

  assign codigo        = codigo_q;
  assign codigo_valido = valido_q;
  assign erro_paridade = erro_par_q;
  assign erro_quadro   = erro_quad_q;

endmodule

// File: rtl/ps2_controles_jogadores.sv
// PS/2 keyboard to arcade controls: prefix tracking and per-player up/down/start decode.
module ps2_controles_jogadores
  import ps2_pkg::*;
#(
  parameter int unsigned NUM_JOGADORES   = 2,
  parameter int unsigned TIMEOUT_CICLOS  = 16380,
  parameter int unsigned LARGURA_TIMEOUT = 15
) (
  input logic                       relogio50,
  input logic                       inicializa,
  ps2_controles_jogadores_if.master bus
);
  logic [7:0]               codigo;
  logic                     codigo_valido;
  logic                     liberar_q, estendido_q;
  logic                     eh_liberar, eh_estendido, eh_ignorado, eh_overflow;
  logic                     tecla_valida, limpa_tudo;
  logic [NUM_JOGADORES-1:0] sobe_v, desce_v, inicia_v;

  ps2_receptor #(
    .TIMEOUT_CICLOS  (TIMEOUT_CICLOS),
    .LARGURA_TIMEOUT (LARGURA_TIMEOUT)
  ) u_receptor (
    .relogio50     (relogio50),
    .inicializa    (inicializa),
    .ps2relogio    (bus.ps2relogio),
    .ps2dados      (bus.ps2dados),
    .codigo        (codigo),
    .codigo_valido (codigo_valido),
    .erro_paridade (bus.erro_paridade),
    .erro_quadro   (bus.erro_quadro)
  );

  assign eh_liberar   = (codigo == COD_LIBERAR);
  assign eh_estendido = (codigo == COD_ESTENDIDO);
  assign eh_ignorado  = (codigo == COD_PAUSA);
  assign eh_overflow  = (codigo == COD_OVF_ZERO) || (codigo == COD_OVF_UM);
  assign limpa_tudo   = codigo_valido & eh_overflow;
  assign tecla_valida = codigo_valido & ~eh_liberar & ~eh_estendido & ~eh_ignorado & ~eh_overflow;

  always_ff @(posedge relogio50 or posedge inicializa) begin
    if (inicializa) begin
      liberar_q   <= 1'b0;
      estendido_q <= 1'b0;
    end else if (codigo_valido) begin
      if (eh_liberar) begin
        liberar_q <= 1'b1;
      end else if (eh_estendido) begin
        estendido_q <= 1'b1;
      end else if (!eh_ignorado) begin
        liberar_q   <= 1'b0;
        estendido_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_JOGADORES; i++) begin : g_jogador
    logic sobe_q, desce_q, inicia_q, held_q;
    logic casa_sobe, casa_desce, casa_inicia;

    assign casa_sobe   = tecla_casa(TECLAS_SOBE[i], estendido_q, codigo);
    assign casa_desce  = tecla_casa(TECLAS_DESCE[i], estendido_q, codigo);
    assign casa_inicia = tecla_casa(TECLAS_INICIA[i], estendido_q, codigo);

    always_ff @(posedge relogio50 or posedge inicializa) begin
      if (inicializa) begin
        sobe_q   <= 1'b0;
        desce_q  <= 1'b0;
        inicia_q <= 1'b0;
        held_q   <= 1'b0;
      end else begin
        inicia_q <= 1'b0;
        if (limpa_tudo) begin
          sobe_q  <= 1'b0;
          desce_q <= 1'b0;
          held_q  <= 1'b0;
        end else if (tecla_valida) begin
          // Last direction pressed wins; a release only drops its own direction.
          if (casa_sobe) begin
            sobe_q <= ~liberar_q;
            if (!liberar_q) desce_q <= 1'b0;
          end
          if (casa_desce) begin
            desce_q <= ~liberar_q;
            if (!liberar_q) sobe_q <= 1'b0;
          end
          if (casa_inicia) begin
            if (liberar_q) begin
              held_q <= 1'b0;
            end else if (!held_q) begin
              inicia_q <= 1'b1;
              held_q   <= 1'b1;
            end
          end
        end
      end
    end

    assign sobe_v[i]   = sobe_q;
    assign desce_v[i]  = desce_q;
    assign inicia_v[i] = inicia_q;
  end

  assign bus.sobe          = sobe_v;
  assign bus.desce         = desce_v;
  assign bus.inicia        = inicia_v;
  assign bus.codigo        = codigo;
  assign bus.codigo_valido = codigo_valido;

endmodule

// File: tb/tb_ps2_controles_jogadores.sv
// Scoreboard bench: frames are driven bit by bit, expected receiver events queued and popped.
module tb_ps2_controles_jogadores;
  localparam int unsigned NJ      = 4;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned MEIA    = 10;

  typedef struct {
    int         tipo;   // 0 codigo, 1 erro_paridade, 2 erro_quadro
    logic [7:0] valor;
  } evento_t;

  logic relogio50  = 1'b0;
  logic inicializa = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   ciclo = 0;
  int   ultima_borda = 0;
  int   ciclo_valido = 0;
  int   ciclo_sobe0  = 0;
  int   cnt_inicia = 0;
  int   cnt_largo  = 0;
  logic inicia0_ant = 1'b0;
  logic sobe0_ant   = 1'b0;
  evento_t esperado[$];

  ps2_controles_jogadores_if #(.NUM_JOGADORES(NJ)) bus ();

  ps2_controles_jogadores #(
    .NUM_JOGADORES   (NJ),
    .TIMEOUT_CICLOS  (TIMEOUT),
    .LARGURA_TIMEOUT (8)
  ) dut (
    .relogio50  (relogio50),
    .inicializa (inicializa),
    .bus        (bus)
  );

  always #10 relogio50 = ~relogio50;
  always @(posedge relogio50) ciclo <= ciclo + 1;

  task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  always @(negedge relogio50) begin
    int      tipo_obs;
    evento_t e;
    if (!inicializa && (bus.codigo_valido || bus.erro_paridade || bus.erro_quadro)) begin
      tipo_obs = bus.codigo_valido ? 0 : (bus.erro_paridade ? 1 : 2);
      if (bus.codigo_valido) ciclo_valido = ciclo;
      if (esperado.size() == 0) begin
        checa("evento_extra", tipo_obs, 99);
      end else begin
        e = esperado.pop_front();
        checa("tipo_evento", tipo_obs, e.tipo);
        if (e.tipo == 0) checa("codigo", bus.codigo, e.valor);
      end
    end
    if (bus.inicia[0]) cnt_inicia++;
    if (bus.inicia[0] && inicia0_ant) cnt_largo++;
    inicia0_ant = bus.inicia[0];
    if (bus.sobe[0] && !sobe0_ant) ciclo_sobe0 = ciclo;
    sobe0_ant = bus.sobe[0];
  end

  task automatic espera(input int n);
    repeat (n) @(posedge relogio50);
    #1;
  endtask

  task automatic envia_bit(input logic b);
    bus.ps2dados = b;
    espera(MEIA);
    bus.ps2relogio = 1'b0;
    ultima_borda = ciclo;
    espera(MEIA);
    bus.ps2relogio = 1'b1;
  endtask

  task automatic envia_quadro(input logic [7:0] b, input bit par_ruim, input bit parada_ruim);
    logic [10:0] q;
    logic        p;
    evento_t     e;
    p = (~^b) ^ par_ruim;
    q = {~parada_ruim, p, b, 1'b0};
    e.tipo  = (par_ruim || parada_ruim) ? 1 : 0;
    e.valor = b;
    esperado.push_back(e);
    for (int k = 0; k < 11; k++) envia_bit(q[k]);
    espera(6);
  endtask

  task automatic tecla(input logic [7:0] b);
    envia_quadro(b, 1'b0, 1'b0);
  endtask

  task automatic checa_saidas(input string tag, input logic [NJ-1:0] s, input logic [NJ-1:0] d);
    checa({tag, "_sobe"}, 32'(bus.sobe), 32'(s));
    checa({tag, "_desce"}, 32'(bus.desce), 32'(d));
  endtask

  initial begin
    #(2ms);
    $display("FAIL watchdog: obtido=timeout esperado=fim");
    $fatal(1);
  end

  initial begin
    bus.ps2relogio = 1'b1;
    bus.ps2dados   = 1'b1;
    espera(3);
    checa("reset_codigo", 32'(bus.codigo), 32'h00);
    checa_saidas("reset", 4'b0000, 4'b0000);
    inicializa = 1'b0;
    espera(5);

    // Press a, check receiver and decode latency, release.
    tecla(8'h1C);
    checa("lat_valido", 32'(ciclo_valido - ultima_borda), 32'd3);
    checa("lat_sobe", 32'(ciclo_sobe0 - ciclo_valido), 32'd1);
    checa_saidas("t1_press", 4'b0001, 4'b0000);
    tecla(8'hF0); tecla(8'h1C);
    checa_saidas("t1_rel", 4'b0000, 4'b0000);

    // Last pressed direction wins; releases only drop their own bit.
    tecla(8'h1C); tecla(8'h1A);
    checa_saidas("t2_ambos", 4'b0000, 4'b0001);
    tecla(8'hF0); tecla(8'h1C);
    checa_saidas("t2_rel_a", 4'b0000, 4'b0001);
    tecla(8'hF0); tecla(8'h1A);
    checa_saidas("t2_rel_z", 4'b0000, 4'b0000);

    // Extended arrow key only matches with the E0 prefix.
    tecla(8'hE0); tecla(8'h75);
    checa_saidas("t3_seta", 4'b1000, 4'b0000);
    tecla(8'hE0); tecla(8'hF0); tecla(8'h75);
    checa_saidas("t3_seta_rel", 4'b0000, 4'b0000);
    tecla(8'h75);
    checa_saidas("t3_nu", 4'b0000, 4'b0000);
    tecla(8'hE0); tecla(8'hE1); tecla(8'h75);
    checa_saidas("t3_e1", 4'b1000, 4'b0000);
    tecla(8'hE0); tecla(8'hF0); tecla(8'h75);
    checa_saidas("t3_e1_rel", 4'b0000, 4'b0000);

    // Start key with typematic repeats.
    tecla(8'h76);
    checa("t4_pulso1", 32'(cnt_inicia), 32'd1);
    tecla(8'h76); tecla(8'h76);
    checa("t4_repeticao", 32'(cnt_inicia), 32'd1);
    tecla(8'hF0); tecla(8'h76); tecla(8'h76);
    checa("t4_pulso2", 32'(cnt_inicia), 32'd2);

    // Overflow clears levels, held flags and prefixes.
    tecla(8'h1C); tecla(8'h3A);
    checa_saidas("ovf_antes", 4'b0001, 4'b0010);
    tecla(8'hFF);
    checa_saidas("ovf_ff", 4'b0000, 4'b0000);
    tecla(8'h76);
    checa("ovf_held", 32'(cnt_inicia), 32'd3);
    tecla(8'hF0); tecla(8'h00); tecla(8'h1C);
    checa_saidas("ovf_prefixo", 4'b0001, 4'b0000);
    tecla(8'hF0); tecla(8'h76);

    // Bad parity and bad stop bit are rejected without decoding.
    tecla(8'hF0);
    envia_quadro(8'h1C, 1'b1, 1'b0);
    checa("par_codigo", 32'(bus.codigo), 32'hF0);
    checa_saidas("par_ruim", 4'b0001, 4'b0000);
    tecla(8'h1C);
    checa_saidas("par_rel", 4'b0000, 4'b0000);
    envia_quadro(8'h1A, 1'b0, 1'b1);
    checa_saidas("parada_ruim", 4'b0000, 4'b0000);

    // Partial frame times out, next frame is received cleanly.
    begin
      evento_t e;
      e.tipo = 2; e.valor = 8'h00;
      esperado.push_back(e);
      envia_bit(1'b0);
      for (int k = 0; k < 4; k++) envia_bit(1'b1);
      espera(TIMEOUT + 30);
      checa("quadro_pendente", 32'(esperado.size()), 32'd0);
    end
    tecla(8'h42);
    checa_saidas("pos_timeout", 4'b0010, 4'b0000);

    // Asynchronous reset mid-frame.
    envia_bit(1'b0);
    envia_bit(1'b1);
    envia_bit(1'b0);
    #3;
    inicializa = 1'b1;
    #1;
    checa_saidas("reset_meio", 4'b0000, 4'b0000);
    checa("reset_meio_codigo", 32'(bus.codigo), 32'h00);
    bus.ps2relogio = 1'b1;
    bus.ps2dados   = 1'b1;
    espera(4);
    inicializa = 1'b0;
    espera(4);
    tecla(8'h1C);
    checa_saidas("pos_reset", 4'b0001, 4'b0000);

    espera(20);
    checa("fila_final", 32'(esperado.size()), 32'd0);
    checa("inicia_largura", 32'(cnt_largo), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_controles_jogadores.md
Name: ps2_controles_jogadores

Overview:
Parametrised PS/2 keyboard receiver that emulates up to four simple arcade controls (sobe/desce/inicia). It sits between the board's PS2_CLK/PS2_DAT pins and the game core, and replaces the two-player fixed decoder. Compared with that decoder it adds:
- full frame checking (start, odd parity, stop)
- an inter-edge timeout
- E0-extended key support
- edge-pulsed start signals
- error reporting

Parameters:
NUM_JOGADORES, 2, number of controls decoded (1..4)
TIMEOUT_CICLOS, 16380, relogio50 cycles without a PS/2 falling edge before a partial frame is discarded (about 328 us at 50 MHz)
LARGURA_TIMEOUT, 15, width of the timeout counter (must hold TIMEOUT_CICLOS)

Ports:
relogio50  in  1  system clock, 50 MHz
inicializa  in  1  asynchronous, active-high reset
ps2relogio  in  1  raw PS/2 clock pin (asynchronous)
ps2dados  in  1  raw PS/2 data pin (asynchronous)
sobe  out  NUM_JOGADORES  level; up held, per player
desce  out  NUM_JOGADORES  level; down held, per player
inicia  out  NUM_JOGADORES  1-cycle pulse on start-key press
codigo  out  8  last valid scan byte
codigo_valido  out  1  1-cycle pulse when codigo updates
erro_paridade  out  1  1-cycle pulse on a bad parity or stop bit
erro_quadro  out  1  1-cycle pulse on a timeout mid-frame

Behaviour:
- Reset (asynchronous, active-high). On reset all outputs are 0, codigo is 8'h00, the FSMs go to OCIOSO, and the prefix and held flags are cleared.
- Synchronisation:
  - Both pins pass through 2 flip-flops.
  - A falling edge is detected when the registered clock was 1 and the synchronised clock is 0. This gives one "amostra" pulse per edge.
- Receive FSM:
  - OCIOSO: on amostra with data=0 (start bit), go to DADOS with bit counter 0. Data=1 on amostra is ignored.
  - DADOS: each amostra shifts data in LSB first. After 8 bits go to PARIDADE.
  - PARIDADE: on amostra, store the parity bit and go to PARADA.
  - PARADA: on amostra, check stop=1 and odd parity over D0..D7+P. If both pass, register codigo and pulse codigo_valido on the next cycle. If either fails, pulse erro_paridade. In both cases return to OCIOSO.
- Timeout:
  - The counter clears on every amostra and saturates at its maximum.
  - If it reaches TIMEOUT_CICLOS while the FSM is not in OCIOSO, pulse erro_quadro, go to OCIOSO, and discard the partial byte.
  - Reaching TIMEOUT_CICLOS in OCIOSO has no effect.
- Decode (acts on codigo_valido):
  - 8'hF0 sets the liberar flag. 8'hE0 sets the estendido flag. Neither produces any other action.
  - Any other byte is looked up as {estendido, byte}. Both flags are cleared afterwards, whether the byte matched or not.
  - 8'hE1 is ignored entirely; flags are unchanged.
  - 8'h00 and 8'hFF (keyboard overflow) clear all sobe, desce and held flags and both prefix flags.
- Key map (player index: sobe / desce / inicia):
  - 0: 1C "a" / 1A "z" / 76 ESC
  - 1: 42 "k" / 3A "m" / 05 F1
  - 2: 2C "t" / 34 "g" / 06 F2
  - 3: E0 75 up-arrow / E0 72 down-arrow / 04 F3
  - Entries for players >= NUM_JOGADORES are not matched.
- Action rules:
  - Press of up: sobe[i]=1 and desce[i]=0 (last pressed wins).
  - Press of down: the symmetric case.
  - Release clears only its own bit.
- Start key:
  - The first press pulses inicia[i] for exactly 1 cycle and sets held[i].
  - Typematic repeats while held[i] is set produce no pulse.
  - Release clears held[i].
- Latency: from the amostra of the stop bit to codigo_valido is 1 cycle; to the sobe/desce/inicia update is 2 cycles.
- Simultaneous events: a timeout and an amostra in the same cycle resolve in favour of the amostra.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (OCIOSO, DADOS, PARIDADE, PARADA)
  - the scan-code constants (F0, E0, E1, overflow codes, and the 12 key codes with their extended flag)
  - the MAX_JOGADORES=4 constant
- One sub-module, ps2_receptor: synchroniser, receive FSM and timeout, outputting codigo, codigo_valido and the two error pulses.
- The top level holds the prefix flags and the per-player decode, built with a generate loop over NUM_JOGADORES.

Test Plan:
1. Frame 1C (odd parity P=0), then F0 1C, bit period 60 us → codigo_valido pulses; sobe[0]=1 two cycles after the first stop bit; sobe[0]=0 after the release.
2. Press 1C, then 1A, without release → sobe[0]=0, desce[0]=1. Release 1C → no change. Release 1A → desce[0]=0.
3. With NUM_JOGADORES=4: E0 75, then 75 alone → sobe[3]=1 only after E0 75. The bare 75 leaves all outputs 0.
4. ESC sent 3 times (typematic), then F0 76, then 76 → inicia[0] pulses exactly twice, each pulse 1 cycle wide.
5. Frame 1C with P=1 → erro_paridade pulses once; codigo_valido stays low; sobe unchanged.
6. 5 bits sent, then idle 400 us → erro_quadro pulses once. A following valid 42 frame is then received correctly (sobe[1]=1). Also assert inicializa mid-frame → all outputs 0 at once.
